// File: rtl/pll_reset_seq.sv
// Reset sequencer for a PLL clocking stage: pulses PLL RST, waits for stable lock,
// then releases the user reset. Lock timeouts and losses are counted for debug.
module pll_reset_seq #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       user_rst,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam longint MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                             longint'(RST_PULSE_CYCLES) : longint'(LOCK_STABLE_CYCLES);
  localparam longint MAX_P = (MAX_A > longint'(LOCK_TIMEOUT_CYCLES)) ?
                             MAX_A : longint'(LOCK_TIMEOUT_CYCLES);

  if ((MAX_P - 1) >= (longint'(1) << CNT_WIDTH)) begin : g_cnt_too_narrow
    $error("pll_reset_seq: CNT_WIDTH too small for the configured cycle counts");
  end

  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 sync1_q, locked_s_q;
  logic                 pll_rst_q, user_rst_q;
  logic [7:0]           retry_q, loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      retry_q    <= 8'd0;
      loss_q     <= 8'd0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE: begin
          // A lock drop takes priority over a completing stable window.
          if (!locked_s_q) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            user_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_q <= '0;
          if (!locked_s_q) begin
            state_q    <= RESET_PLL;
            pll_rst_q  <= 1'b1;
            user_rst_q <= 1'b1;
            loss_q     <= (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end
        default: begin
          state_q    <= RESET_PLL;
          cnt_q      <= '0;
          pll_rst_q  <= 1'b1;
          user_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign user_rst  = user_rst_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule
